// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encoding and
// helpers that locate the remainder (HI) and quotient (LO) halves of a result.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_e;

    // Result is {remainder, quotient}: HI occupies [2W-1:W], LO occupies [W-1:0].
    function automatic int hi_msb(input int width);
        return 2 * width - 1;
    endfunction

    function automatic int hi_lsb(input int width);
        return width;
    endfunction

    function automatic int lo_msb(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and keep the trial difference when it does not borrow.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in WIDTH+1 bits and the top bit of the difference is the borrow.
    always_comb begin
        shifted  = {rem, dvd_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider for the EX stage HI/LO path.
// One quotient bit per clock; result = {remainder, quotient}, all outputs registered.
module div_unit
    import div_pkg::*;
#(
    parameter int   WIDTH = 32,
    localparam int  CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               annul,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy,
    output logic               div_by_zero
);

    div_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  dvd_q;
    logic [WIDTH-1:0]  dsr_q;
    logic              sign1_q;
    logic              sign2_q;
    logic              sop_q;

    logic [WIDTH-1:0]  abs1;
    logic [WIDTH-1:0]  abs2;
    logic [WIDTH-1:0]  rem_nx;
    logic              q_bit;
    logic [WIDTH-1:0]  quo_nx;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;
    logic              last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_bit  (dvd_q[WIDTH-1]),
        .divisor  (dsr_q),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    // The dividend register doubles as the quotient: each step shifts one
    // dividend bit out of the top and one quotient bit in at the bottom.
    assign quo_nx    = {dvd_q[WIDTH-2:0], q_bit};
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // so no path leaves it unassigned and no latch is inferred.
        abs1    = opdata1;
        abs2    = opdata2;
        quo_fix = quo_nx;
        rem_fix = rem_nx;
        if (signed_op && opdata1[WIDTH-1]) abs1 = -opdata1;
        if (signed_op && opdata2[WIDTH-1]) abs2 = -opdata2;
        if (sop_q && (sign1_q ^ sign2_q))  quo_fix = -quo_nx;
        if (sop_q && sign1_q)              rem_fix = -rem_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge values of the others.
            state       <= DIV_IDLE;
            cnt         <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            sign1_q     <= 1'b0;
            sign2_q     <= 1'b0;
            sop_q       <= 1'b0;
            result      <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start && !annul) begin
                        busy <= 1'b1;
                        if (opdata2 == '0) begin
                            state <= DIV_BYZERO;
                        end else begin
                            state   <= DIV_ON;
                            cnt     <= '0;
                            rem_q   <= '0;
                            dvd_q   <= abs1;
                            dsr_q   <= abs2;
                            sign1_q <= opdata1[WIDTH-1];
                            sign2_q <= opdata2[WIDTH-1];
                            sop_q   <= signed_op;
                        end
                    end
                end
                DIV_BYZERO: begin
                    busy <= 1'b0;
                    if (annul) begin
                        state <= DIV_IDLE;
                    end else begin
                        state       <= DIV_END;
                        result      <= '0;
                        ready       <= 1'b1;
                        div_by_zero <= 1'b1;
                    end
                end
                DIV_ON: begin
                    // A flush wins over a completion landing on the same edge.
                    if (annul) begin
                        state <= DIV_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem_q <= rem_nx;
                        dvd_q <= quo_nx;
                        cnt   <= cnt + CNT_W'(1);
                        if (last_step) begin
                            result[hi_msb(WIDTH):hi_lsb(WIDTH)] <= rem_fix;
                            result[lo_msb(WIDTH):0]             <= quo_fix;
                            ready       <= 1'b1;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b0;
                            state       <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    if (!start) begin
                        state       <= DIV_IDLE;
                        result      <= '0;
                        ready       <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule
